// File: rtl/ram_responder_model.sv
// ============================================================================
// Module  : ram_responder_model
// Brief   : Block-RAM responder for the simple RAM request handshake, with
//           modelled calibration, write-busy time and fixed read latency.
//           Optional macro RAM_RESP_CLEAR_EN zeroes the memory during INIT.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_responder_model #(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 8,
    parameter int DEPTH_W      = 8,
    parameter int READ_LATENCY = 4,
    parameter int INIT_CYCLES  = 16,
    parameter int WRITE_BUSY   = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_enable,
    input  logic              read_request,
    input  logic              read_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              rdy,
    output logic              rd_data_pres,
    output logic [ADDR_W-1:0] max_ram_address
);

    localparam int                DEPTH    = 1 << DEPTH_W;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_WBUSY   = 3'd2,
        S_RWAIT   = 3'd3,
        S_PRESENT = 3'd4
    } state_t;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rdy_q, rdy_d;
    logic              pres_q, pres_d;

    logic              mem_we;
    logic [DEPTH_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_in_range, rd_in_range;
    logic              init_done, sweep_done;

    assign wr_in_range = (address <= MAX_ADDR);
    assign rd_in_range = (rd_addr_q <= MAX_ADDR);
    assign init_done   = (cnt_q == 8'(INIT_CYCLES - 1));

`ifdef RAM_RESP_CLEAR_EN
    logic [DEPTH_W-1:0] sweep_q, sweep_d;

    assign sweep_done = &sweep_q;

    always_comb begin
        sweep_d = sweep_q;
        if (state_q == S_INIT && !sweep_done)
            sweep_d = sweep_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) sweep_q <= '0;
        else        sweep_q <= sweep_d;
    end
`else
    assign sweep_done = 1'b1;
`endif

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address[DEPTH_W-1:0];
        mem_wdata = data_in;
        if (state_q == S_IDLE && write_enable && wr_in_range)
            mem_we = 1'b1;
`ifdef RAM_RESP_CLEAR_EN
        if (state_q == S_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_q;
            mem_wdata = '0;
        end
`endif
    end

    // Storage is deliberately not reset so contents survive a reset.
    always_ff @(posedge CLK) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        data_out_d = data_out_q;
        pres_d     = pres_q;
        case (state_q)
            S_INIT: begin
                if (init_done && sweep_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!init_done) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_IDLE: begin
                // A same-cycle write lands first, so the read sees new data.
                if (read_request) begin
                    rd_addr_d = address;
                    cnt_d     = '0;
                    state_d   = S_RWAIT;
                end else if (write_enable && WRITE_BUSY > 0) begin
                    cnt_d   = '0;
                    state_d = S_WBUSY;
                end
            end
            S_WBUSY: begin
                if (cnt_q == 8'(WRITE_BUSY - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RWAIT: begin
                if (cnt_q == 8'(READ_LATENCY - 1)) begin
                    data_out_d = rd_in_range ? mem[rd_addr_q[DEPTH_W-1:0]] : '1;
                    pres_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_PRESENT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PRESENT: begin
                if (read_ack) begin
                    pres_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
                pres_d  = 1'b0;
            end
        endcase
        rdy_d = (state_d == S_IDLE) || (state_d == S_RWAIT) || (state_d == S_PRESENT);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            data_out_q <= '0;
            rdy_q      <= 1'b0;
            pres_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            data_out_q <= data_out_d;
            rdy_q      <= rdy_d;
            pres_q     <= pres_d;
        end
    end

    assign data_out        = data_out_q;
    assign rdy             = rdy_q;
    assign rd_data_pres    = pres_q;
    assign max_ram_address = MAX_ADDR;

endmodule

`default_nettype wire

// File: tb/tb_ram_responder_model.sv
// ============================================================================
// Module  : tb_ram_responder_model
// Brief   : Directed self-checking bench for ram_responder_model (defaults).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_responder_model;

    logic        CLK;
    logic        reset;
    logic [25:0] address;
    logic [7:0]  data_in;
    logic        write_enable;
    logic        read_request;
    logic        read_ack;
    logic [7:0]  data_out;
    logic        rdy;
    logic        rd_data_pres;
    logic [25:0] max_ram_address;

    int err_cnt;
    int chk_cnt;

    ram_responder_model dut (
        .CLK             (CLK),
        .reset           (reset),
        .address         (address),
        .data_in         (data_in),
        .write_enable    (write_enable),
        .read_request    (read_request),
        .read_ack        (read_ack),
        .data_out        (data_out),
        .rdy             (rdy),
        .rd_data_pres    (rd_data_pres),
        .max_ram_address (max_ram_address)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!rdy && n < 400) begin
            tick();
            n++;
        end
        check(tag, 32'(rdy), 32'd1);
    endtask

    task automatic do_write(input logic [25:0] a, input logic [7:0] d);
        wait_rdy("wr_rdy");
        address      = a;
        data_in      = d;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    // Issues a read (optionally with a same-cycle write) and waits for data.
    task automatic start_read(input logic [25:0] a, input logic we, input logic [7:0] d,
                              input string tag);
        int n = 0;
        wait_rdy("rd_rdy");
        address      = a;
        data_in      = d;
        write_enable = we;
        read_request = 1'b1;
        tick();
        write_enable = 1'b0;
        read_request = 1'b0;
        while (!rd_data_pres && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd3 + 32'd1);
    endtask

    task automatic finish_read(input string tag);
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
        check({tag, "_pres_clr"}, 32'(rd_data_pres), 32'd0);
    endtask

    task automatic do_read(input logic [25:0] a, input logic [7:0] exp, input string tag);
        start_read(a, 1'b0, 8'h00, tag);
        check({tag, "_data"}, 32'(data_out), 32'(exp));
        finish_read(tag);
    endtask

    initial begin
        logic [7:0] held_data;
        logic       held_ok;

        err_cnt      = 0;
        chk_cnt      = 0;
        reset        = 1'b0;
        address      = '0;
        data_in      = '0;
        write_enable = 1'b0;
        read_request = 1'b0;
        read_ack     = 1'b0;

        // Reset state and calibration window
        repeat (3) @(negedge CLK);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_pres", 32'(rd_data_pres), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("max_addr", 32'(max_ram_address), 32'h0000_00FF);
        reset = 1'b1;
        repeat (15) tick();
        check("init_rdy_low_15", 32'(rdy), 32'd0);
        tick();
        check("init_rdy_high_16", 32'(rdy), 32'd1);

        // Write 0xA5 to 0x3C, write-busy window, then read back
        do_write(26'h3C, 8'hA5);
        check("wbusy_rdy_low", 32'(rdy), 32'd0);
        tick();
        check("wbusy_rdy_back", 32'(rdy), 32'd1);
        do_read(26'h3C, 8'hA5, "rd_3c");
        check("rd_3c_dout_kept", 32'(data_out), 32'hA5);

        // Same-cycle write and read, long hold without ack
        start_read(26'h10, 1'b1, 8'h5A, "wr_rd_10");
        check("wr_rd_10_data", 32'(data_out), 32'h5A);
        held_data = data_out;
        held_ok   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!rd_data_pres || data_out !== held_data) held_ok = 1'b0;
        end
        check("hold_pres_data", 32'(held_ok), 32'd1);
        check("hold_pres_final", 32'(rd_data_pres), 32'd1);
        finish_read("wr_rd_10");

        // Out-of-range write dropped; aliasing word 0 untouched
        do_write(26'h000, 8'h77);
        do_write(26'h100, 8'h11);
        do_read(26'h100, 8'hFF, "rd_oor");
        do_read(26'h000, 8'h77, "rd_00");

        // Reset in RWAIT discards the read; contents survive
        wait_rdy("rwait_rdy");
        address      = 26'h3C;
        read_request = 1'b1;
        tick();
        read_request = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rst_rwait_pres", 32'(rd_data_pres), 32'd0);
        check("rst_rwait_dout", 32'(data_out), 32'd0);
        check("rst_rwait_rdy", 32'(rdy), 32'd0);
        tick();
        tick();
        check("rst_hold_pres", 32'(rd_data_pres), 32'd0);
        reset = 1'b1;
        do_read(26'h3C, 8'hA5, "rd_after_rst");

        // Initiator-style loop: write dip to switches address, read it back
        for (int l = 0; l < 3; l++) begin
            do_write(26'h22, 8'hC3);
            do_read(26'h22, 8'hC3, "fsm_loop");
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ram_responder_model.md
# ram_responder_model

On-chip responder for the team's simple RAM request interface, the same address / data_in / write_enable / read_request / read_ack / data_out / rdy / rd_data_pres handshake that our read/write FSMs drive. It stands in for the DDR2 wrapper: bring-up on boards without DDR2, and simulation of initiator FSMs with deterministic latency. Storage is a 2^DEPTH_W × DATA_W block RAM. `rdy` models controller calibration and write-busy time, and read latency is configurable.

## Interface
Parameters:
- `ADDR_W`, 26, address width, fixed by the interface
- `DATA_W`, 8, data word width
- `DEPTH_W`, 8, log2 of the implemented word count
- `READ_LATENCY`, 4, cycles from read acceptance to `rd_data_pres`; legal range 1..15
- `INIT_CYCLES`, 16, cycles `rdy` stays low after reset release; legal range 1..255
- `WRITE_BUSY`, 1, cycles `rdy` stays low after an accepted write; legal range 0..7

Ports:
- `CLK`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `address`, in, ADDR_W: word address.
- `data_in`, in, DATA_W: write data.
- `write_enable`, in, 1: write request, level-sampled.
- `read_request`, in, 1: read request, level-sampled.
- `read_ack`, in, 1: initiator consumed `data_out`.
- `data_out`, out, DATA_W: read data, registered.
- `rdy`, out, 1: responder able to accept a request.
- `rd_data_pres`, out, 1: `data_out` valid.
- `max_ram_address`, out, ADDR_W: constant 2^DEPTH_W − 1.

## Operation
- States: INIT, IDLE, WBUSY, RWAIT, PRESENT.
- Reset asserted (low), at any time: state INIT, counters 0, `rdy`=0, `rd_data_pres`=0, `data_out`=0. Any in-flight read is discarded. Memory contents are untouched unless `RAM_RESP_CLEAR_EN` is defined.
- INIT: counts INIT_CYCLES, then goes to IDLE. `rdy`=1 in IDLE, RWAIT and PRESENT; `rdy`=0 in INIT and WBUSY.
- In range means address ≤ max_ram_address, i.e. bits above DEPTH_W are zero.
- IDLE, `write_enable`=1: an in-range word is written at this edge; an out-of-range write is dropped silently. Goes to WBUSY if WRITE_BUSY>0, else stays in IDLE.
- WBUSY: counts WRITE_BUSY cycles, then returns to IDLE.
- IDLE, `read_request`=1: the address is latched and the state goes to RWAIT. If `write_enable` is also 1 in the same cycle, the write is performed and the read returns the new data (write-first). The read then takes priority over WBUSY: the state goes to RWAIT.
- RWAIT: counts READ_LATENCY−1 cycles. On the final edge, `data_out` loads mem[latched address], or all-ones if out of range; `rd_data_pres` is set and the state goes to PRESENT.
- PRESENT: `data_out` and `rd_data_pres` are held until `read_ack`=1 is sampled. On that edge `rd_data_pres` clears and the state goes to IDLE. `data_out` keeps its value until the next read load.
- `read_ack` is ignored outside PRESENT.
- `write_enable` and `read_request` are ignored outside IDLE; they are not queued.
- Held `write_enable` in IDLE writes again every eligible cycle. This is harmless for same address and data.

## Timing
- Read accepted at edge T → `rd_data_pres` rises at edge T+READ_LATENCY.
- `read_ack` sampled high at edge A → `rd_data_pres`=0 after A. A new request is accepted at the earliest at edge A+1.
- Write accepted at edge T → readable by a read accepted at T. With no read, `rdy`=0 for edges T+1..T+WRITE_BUSY.
- After reset release, `rdy` rises after INIT_CYCLES edges. With `RAM_RESP_CLEAR_EN` defined it rises after max(INIT_CYCLES, 2^DEPTH_W) edges.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `RAM_RESP_CLEAR_EN` defined: INIT also sweeps an address counter 0..2^DEPTH_W−1, writing 0 to each word, one word per cycle. INIT exits only when both the sweep and the INIT_CYCLES count have finished. After every reset, all reads return 0 until written.
- Not defined: no sweep. Contents survive reset; initial contents are undefined.

## Test plan
- Reset release, defaults: `rdy`=0 for 16 cycles and 1 from cycle 17. `max_ram_address`=0x00000FF. With `RAM_RESP_CLEAR_EN`: `rdy` rises at cycle 256 and a read of 0x05 returns 0x00.
- Write 0xA5 to 0x3C, then read 0x3C: `rdy` is low 1 cycle after the write. `rd_data_pres` rises exactly 4 edges after the read is accepted with `data_out`=0xA5, and falls on the edge after `read_ack` is sampled.
- `write_enable` and `read_request` together, address 0x10, data 0x5A: the read returns 0x5A. Hold `read_ack` low for 20 cycles: `rd_data_pres` and `data_out` are held unchanged.
- Out-of-range address 0x100: the write of 0x11 is dropped, a read returns 0xFF, and a subsequent read of 0x00 is unaffected.
- Assert `reset` in RWAIT: `rd_data_pres` stays 0 and `data_out`=0; after INIT, a read of a previously written address returns the old data (macro undefined).
- Drive the team's read/write FSM with switches=0x22 and dip=0xC3 through 3 full loops: each loop completes, the read-back value is 0xC3, and no handshake deadlock occurs.
